axi_rd_burst_slave: RTL

AXI_RD_BURST_SLAVE -- requirements
Module: axi_rd_burst_slave

---
 rtl/axi_pkg.sv | 27 ++
 rtl/axi_burst_addr_gen.sv | 29 ++
 rtl/axi_rd_burst_slave.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared encodings, FSM state type and request legality check for the AXI read burst slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] MAX_ARSIZE  = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_BEAT} rd_state_e;

  // Only the low two address bits matter: any legal beat is at most 4 bytes wide.
  function automatic logic burst_err(input logic [2:0] size, input logic [3:0] len,
                                     input logic [1:0] burst, input logic [1:0] addr_lo);
    logic misalign;
    logic len_ok;
    misalign = (size == 3'd1 && addr_lo[0]) || (size == 3'd2 && addr_lo != 2'b00);
    len_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (size > MAX_ARSIZE) || (burst == BURST_RSVD) ||
           (burst == BURST_WRAP && (!len_ok || misalign));
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [3:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;

  assign w_bytes     = ADDR_WIDTH'(1) << size;
  assign w_wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = (addr & ~(w_bytes - ADDR_WIDTH'(1))) + w_bytes;
      BURST_WRAP: next_addr = (addr & ~w_wrap_mask) | ((addr + w_bytes) & w_wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_burst_slave.sv
// AXI3-style read burst slave: one burst at a time, one memory read per beat,
// illegal bursts answered with SLVERR beats without touching memory.
module axi_rd_burst_slave
  import axi_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   S_ARID,
  input  logic [ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [3:0]            S_ARLEN,
  input  logic [2:0]            S_ARSIZE,
  input  logic [1:0]            S_ARBURST,
  input  logic [1:0]            S_ARLOCK,
  input  logic [3:0]            S_ARCACHE,
  input  logic [2:0]            S_ARPROT,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [ID_WIDTH-1:0]   S_RID,
  output logic [BUS_WIDTH-1:0]  S_RDATA,
  output logic [3:0]            S_RRESP,
  output logic                  S_RLAST,
  output logic                  S_RVALID,
  input  logic                  S_RREADY,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [BUS_WIDTH-1:0]  mem_rdata
);

  rd_state_e             r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_len;
  logic [3:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic                  r_mem_rd;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [BUS_WIDTH-1:0]  r_rdata;
  logic [1:0]            r_rresp;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_ar_err;
  logic                  w_unused;

  assign w_unused = ^{S_ARLOCK, S_ARCACHE, S_ARPROT};
  assign w_ar_err = burst_err(S_ARSIZE, S_ARLEN, S_ARBURST, S_ARADDR[1:0]);

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_err      <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_mem_rd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_arready <= 1'b1;
          if (S_ARVALID && r_arready) begin
            r_arready <= 1'b0;
            r_id      <= S_ARID;
            r_addr    <= S_ARADDR;
            r_len     <= S_ARLEN;
            r_cnt     <= S_ARLEN;
            r_size    <= S_ARSIZE;
            r_burst   <= S_ARBURST;
            r_err     <= w_ar_err;
            if (w_ar_err) begin
              r_state  <= ST_BEAT;
              r_rvalid <= 1'b1;
              r_rlast  <= (S_ARLEN == 4'd0);
              r_rdata  <= '0;
              r_rresp  <= RESP_SLVERR;
            end else begin
              r_state    <= ST_ADDR;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= S_ARADDR;
            end
          end
        end
        ST_ADDR: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_state  <= ST_BEAT;
          r_rvalid <= 1'b1;
          r_rlast  <= (r_cnt == 4'd0);
          r_rdata  <= mem_rdata;
          r_rresp  <= RESP_OKAY;
        end
        ST_BEAT: begin
          if (S_RREADY) begin
            if (r_cnt == 4'd0) begin
              r_state   <= ST_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_cnt  <= r_cnt - 4'd1;
              r_addr <= w_next_addr;
              // Error beats are back-to-back: RVALID stays up, only RLAST moves.
              if (r_err) begin
                r_rlast <= (r_cnt == 4'd1);
              end else begin
                r_state    <= ST_ADDR;
                r_rvalid   <= 1'b0;
                r_rlast    <= 1'b0;
                r_mem_rd   <= 1'b1;
                r_mem_addr <= w_next_addr;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign S_ARREADY = r_arready;
  assign S_RID     = r_id;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = {2'b00, r_rresp};
  assign S_RLAST   = r_rlast;
  assign S_RVALID  = r_rvalid;
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;

endmodule
